// File: rtl/if_id_hazard_controller_pkg.sv
// Shared definitions for the IF/ID hazard controller and its helpers.
// Holds the controller state encoding, the NOP encoding and the default datapath width.
package if_id_hazard_controller_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;
    localparam int unsigned FLUSH_W      = 3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hazardState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// It holds its value whenever it is not enabled.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/if_id_hazard_controller.sv
// Front-end hazard controller: owns IF/ID and enacts stall, flush and memory-hold decisions.
// It also keeps saturating stall/flush statistics and a sticky load-use watchdog flag.
module if_id_hazard_controller
    import if_id_hazard_controller_pkg::*;
#(
    parameter int unsigned XLEN         = DEFAULT_XLEN,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 8,
    parameter int unsigned CNT_W        = 16,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_ENCODING)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    input  logic [XLEN-1:0]  IF_Pc,
    input  logic [XLEN-1:0]  IF_Instr,
    output logic             PCWrite,
    output logic             PipeFreeze,
    output logic             ID_EXBubble,
    output logic [XLEN-1:0]  IF_IDPc,
    output logic [XLEN-1:0]  IF_IDInstr,
    output logic             IF_IDValid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_error
);

    localparam logic [FLUSH_W-1:0] FlushReload = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   StallLimit  = CNT_W'(MAX_STALL - 1);

    hazardState_e state, stateNext, savedState, savedNext, evalState;
    logic [FLUSH_W-1:0] flushLeft, flushLeftNext;
    logic loadIfId, flushSlot, stallInc, runClr;
    logic [CNT_W-1:0] runCount;

    always_comb begin
        PCWrite       = 1'b0;
        PipeFreeze    = 1'b0;
        ID_EXBubble   = 1'b0;
        stateNext     = state;
        savedNext     = savedState;
        flushLeftNext = flushLeft;
        loadIfId      = 1'b0;
        flushSlot     = 1'b0;
        stallInc      = 1'b0;
        // After a memory hold, the interrupted state decides this cycle
        evalState     = (state == MEM_WAIT) ? savedState : state;

        if (MemBusy) begin
            PipeFreeze = 1'b1;
            stateNext  = MEM_WAIT;
            if (state != MEM_WAIT) begin
                savedNext = state;
            end
        end else if (BranchTaken) begin
            flushSlot     = 1'b1;
            flushLeftNext = FlushReload;
            stateNext     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (evalState)
                FLUSH: begin
                    flushSlot     = 1'b1;
                    flushLeftNext = (flushLeft == '0) ? '0 : flushLeft - FLUSH_W'(1);
                    stateNext     = (flushLeft <= FLUSH_W'(1)) ? RUN : FLUSH;
                end
                default: begin
                    if (stall) begin
                        stallInc  = 1'b1;
                        stateNext = LOAD_STALL;
                    end else begin
                        loadIfId  = 1'b1;
                        stateNext = RUN;
                    end
                end
            endcase
        end

        if (flushSlot) begin
            PCWrite     = 1'b1;
            ID_EXBubble = 1'b1;
        end else if (stallInc) begin
            ID_EXBubble = 1'b1;
        end else if (loadIfId) begin
            PCWrite = 1'b1;
        end

        // The watchdog run only survives uninterrupted stalls and memory holds
        runClr = !MemBusy && !stallInc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            savedState  <= RUN;
            flushLeft   <= '0;
            IF_IDPc     <= '0;
            IF_IDInstr  <= NOP_INSTR;
            IF_IDValid  <= 1'b0;
            stall_error <= 1'b0;
        end else begin
            state      <= stateNext;
            savedState <= savedNext;
            flushLeft  <= flushLeftNext;
            if (loadIfId) begin
                IF_IDPc    <= IF_Pc;
                IF_IDInstr <= IF_Instr;
                IF_IDValid <= 1'b1;
            end else if (flushSlot) begin
                IF_IDInstr <= NOP_INSTR;
                IF_IDValid <= 1'b0;
            end
            if (stallInc && (runCount >= StallLimit)) begin
                stall_error <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stallCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (stallInc),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flushCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (flushSlot),
        .count (flush_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_runCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (runClr),
        .en    (stallInc),
        .count (runCount)
    );

endmodule

// File: tb/tb_if_id_hazard_controller.sv
// Scoreboard bench for if_id_hazard_controller: two instances (2-slot flush with 16-bit
// counters, 3-slot flush with 4-bit counters) driven in lockstep against a slot-count model.
module tb_if_id_hazard_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n, stall, BranchTaken, MemBusy;
    logic [31:0] IF_Pc, IF_Instr;

    logic        pcw0, frz0, bub0, val0, err0;
    logic [31:0] pc0, ins0;
    logic [15:0] sc0, fc0;
    logic        pcw1, frz1, bub1, val1, err1;
    logic [31:0] pc1, ins1;
    logic [3:0]  sc1, fc1;

    always #5 clk = ~clk;

    if_id_hazard_controller #(
        .FLUSH_CYCLES (2)
    ) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .BranchTaken (BranchTaken),
        .MemBusy     (MemBusy),
        .IF_Pc       (IF_Pc),
        .IF_Instr    (IF_Instr),
        .PCWrite     (pcw0),
        .PipeFreeze  (frz0),
        .ID_EXBubble (bub0),
        .IF_IDPc     (pc0),
        .IF_IDInstr  (ins0),
        .IF_IDValid  (val0),
        .stall_count (sc0),
        .flush_count (fc0),
        .stall_error (err0)
    );

    if_id_hazard_controller #(
        .FLUSH_CYCLES (3),
        .MAX_STALL    (8),
        .CNT_W        (4)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .BranchTaken (BranchTaken),
        .MemBusy     (MemBusy),
        .IF_Pc       (IF_Pc),
        .IF_Instr    (IF_Instr),
        .PCWrite     (pcw1),
        .PipeFreeze  (frz1),
        .ID_EXBubble (bub1),
        .IF_IDPc     (pc1),
        .IF_IDInstr  (ins1),
        .IF_IDValid  (val1),
        .stall_count (sc1),
        .flush_count (fc1),
        .stall_error (err1)
    );

    typedef struct {
        logic        pcw, frz, bub;
        logic [31:0] pc, instr;
        logic        valid;
        int          sc, fc;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Model: a flush is just "slots still owed"; stall and run need no state of their own
    int          flushLen[2] = '{2, 3};
    int          cntMax[2]   = '{65535, 15};
    int          maxStall[2] = '{8, 8};
    int          slotsLeft[2], consec[2], mSc[2], mFc[2];
    logic        mErr[2], mValid[2];
    logic [31:0] mPc[2], mInstr[2];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %h expected %h", nm, act, req);
        else passed++;
    endtask

    function automatic int satInc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic modelReset(input int d);
        slotsLeft[d] = 0; consec[d] = 0; mSc[d] = 0; mFc[d] = 0;
        mErr[d] = 1'b0; mValid[d] = 1'b0; mPc[d] = '0; mInstr[d] = NOP;
    endtask

    task automatic step(input logic r, input logic st, input logic br, input logic mb,
                        input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic fl;
        @(posedge clk);
        #1;
        rst_n = r;
        stall = r & st; BranchTaken = r & br; MemBusy = r & mb;
        IF_Pc = pc; IF_Instr = ins;
        for (int d = 0; d < 2; d++) begin
            if (!r) modelReset(d);
            fl = !MemBusy && (BranchTaken || slotsLeft[d] > 0);
            e.frz   = MemBusy;
            e.pcw   = !MemBusy && (fl || !stall);
            e.bub   = !MemBusy && (fl || stall);
            e.pc    = mPc[d]; e.instr = mInstr[d]; e.valid = mValid[d];
            e.sc    = mSc[d]; e.fc = mFc[d]; e.err = mErr[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            if (r && !MemBusy) begin
                if (fl) begin
                    if (BranchTaken) slotsLeft[d] = flushLen[d];
                    slotsLeft[d]--;
                    mFc[d] = satInc(mFc[d], cntMax[d]);
                    mInstr[d] = NOP; mValid[d] = 1'b0; consec[d] = 0;
                end else if (stall) begin
                    mSc[d] = satInc(mSc[d], cntMax[d]);
                    consec[d] = satInc(consec[d], cntMax[d]);
                    if (consec[d] >= maxStall[d]) mErr[d] = 1'b1;
                end else begin
                    mPc[d] = pc; mInstr[d] = ins; mValid[d] = 1'b1; consec[d] = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0.PCWrite", 32'(pcw0), 32'(e.pcw));
            chk("d0.PipeFreeze", 32'(frz0), 32'(e.frz));
            chk("d0.ID_EXBubble", 32'(bub0), 32'(e.bub));
            chk("d0.IF_IDPc", pc0, e.pc);
            chk("d0.IF_IDInstr", ins0, e.instr);
            chk("d0.IF_IDValid", 32'(val0), 32'(e.valid));
            chk("d0.stall_count", 32'(sc0), 32'(e.sc));
            chk("d0.flush_count", 32'(fc0), 32'(e.fc));
            chk("d0.stall_error", 32'(err0), 32'(e.err));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1.PCWrite", 32'(pcw1), 32'(e.pcw));
            chk("d1.PipeFreeze", 32'(frz1), 32'(e.frz));
            chk("d1.ID_EXBubble", 32'(bub1), 32'(e.bub));
            chk("d1.IF_IDPc", pc1, e.pc);
            chk("d1.IF_IDInstr", ins1, e.instr);
            chk("d1.IF_IDValid", 32'(val1), 32'(e.valid));
            chk("d1.stall_count", 32'(sc1), 32'(e.sc));
            chk("d1.flush_count", 32'(fc1), 32'(e.fc));
            chk("d1.stall_error", 32'(err1), 32'(e.err));
        end
    end

    initial begin
        int wait_cycles;
        rst_n = 1'b0; stall = 1'b0; BranchTaken = 1'b0; MemBusy = 1'b0;
        IF_Pc = '0; IF_Instr = '0;
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        // Straight-line fetch, then a one-cycle load-use stall with 0x10 in IF/ID
        step(1, 0, 0, 0, 32'h0,  32'h1111_0001);
        step(1, 0, 0, 0, 32'h4,  32'h1111_0002);
        step(1, 0, 0, 0, 32'h8,  32'h1111_0003);
        step(1, 0, 0, 0, 32'h10, 32'h1111_0004);
        step(1, 1, 0, 0, 32'h14, 32'h1111_0005);
        step(1, 0, 0, 0, 32'h14, 32'h1111_0005);
        step(1, 0, 0, 0, 32'h18, 32'h1111_0006);
        // Taken branch, then branch coinciding with stall
        step(1, 0, 1, 0, 32'h1c, 32'h1111_0007);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h100 + 4 * i, 32'h2222_0000 + i);
        step(1, 1, 1, 0, 32'h200, 32'h3333_0000);
        for (int i = 0; i < 4; i++) step(1, i == 0, 0, 0, 32'h204 + 4 * i, 32'h3333_0001 + i);
        // Memory hold in the middle of a flush
        step(1, 0, 1, 0, 32'h300, 32'h4444_0000);
        step(1, 0, 0, 0, 32'h304, 32'h4444_0001);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 32'h308, 32'h4444_0002);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h308 + 4 * i, 32'h4444_0003 + i);
        // Long stall run: watchdog, then 4-bit counter saturation
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 32'h400, 32'h5555_0000);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h400 + 4 * i, 32'h5555_0001 + i);
        // Reset pulse mid-stall
        step(1, 1, 0, 0, 32'h500, 32'h6666_0000);
        step(0, 1, 0, 0, 32'h500, 32'h6666_0000);
        step(1, 0, 0, 0, 32'h504, 32'h6666_0001);
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 12, $urandom & 32'hffff_fffc, $urandom);
        end
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h600, 32'h7777_0000);
        wait_cycles = 0;
        while ((q0.size() > 0 || q1.size() > 0) && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d entries pending, expected 0", q0.size() + q1.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_controller.md
Name: if_id_hazard_controller

Overview:
- Consumer end of the load-use stall request: receives the stall decision from the hazard detector and enacts it on the front of the pipeline.
- Receives the stall, branch redirect and memory-busy conditions. Drives PC write enable, ID/EX bubble insertion and pipe freeze.
- Owns the IF/ID pipeline register, including its valid bit.
- Sits between the fetch stage and the decode stage. Also keeps saturating stall/flush statistics and raises a sticky watchdog error.

Parameters:
- XLEN, 32, width of the PC and instruction.
- FLUSH_CYCLES, 1, number of fetch slots squashed after a taken branch (1..7).
- MAX_STALL, 8, consecutive load-use stall cycles before stall_error is set.
- CNT_W, 16, width of the statistics counters.
- NOP_INSTR, 32'h00000013, encoding loaded into IF/ID on reset and flush (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  load-use stall request from the hazard detector.
- BranchTaken  in  1  EX-stage taken branch/jump; the fetch redirect happens this cycle.
- MemBusy  in  1  data memory not ready; the whole pipe must hold.
- IF_Pc  in  XLEN  PC of the instruction being fetched.
- IF_Instr  in  XLEN  fetched instruction.
- PCWrite  out  1  PC register enable.
- PipeFreeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- ID_EXBubble  out  1  zero the ID/EX control fields this cycle.
- IF_IDPc  out  XLEN  registered PC.
- IF_IDInstr  out  XLEN  registered instruction.
- IF_IDValid  out  1  IF/ID holds a real instruction.
- stall_count  out  CNT_W  saturating count of load-use bubble cycles.
- flush_count  out  CNT_W  saturating count of squashed fetch slots.
- stall_error  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, IF_IDInstr=NOP_INSTR, IF_IDPc=0, IF_IDValid=0.
  - Both counters 0, stall_error=0, internal flush counter 0.
- Outputs PCWrite, PipeFreeze and ID_EXBubble are combinational from state and inputs, with zero latency. Everything else is registered.
- Input priority when several are asserted: MemBusy > BranchTaken > FLUSH state > stall.
- FSM states:
  - RUN: no hazard; PCWrite=1, IF/ID loads IF_Pc/IF_Instr, IF_IDValid<=1.
  - LOAD_STALL: entered on stall=1 from RUN. Each cycle with stall=1: PCWrite=0, IF/ID holds, ID_EXBubble=1, stall_count+1, consecutive-stall counter+1. Return to RUN on the first cycle with stall=0; that cycle behaves as RUN and the consecutive counter clears.
  - FLUSH: entered on BranchTaken=1 from any state except MEM_WAIT. The entry cycle and the following FLUSH_CYCLES-1 cycles each do: PCWrite=1, IF_IDInstr<=NOP_INSTR, IF_IDValid<=0, ID_EXBubble=1, flush_count+1. stall is ignored while in FLUSH. Exit to RUN after FLUSH_CYCLES slots. A new BranchTaken inside FLUSH restarts the slot count.
  - MEM_WAIT: entered whenever MemBusy=1, from any state. While MemBusy=1: PCWrite=0, PipeFreeze=1, ID_EXBubble=0; IF/ID, the counters and the flush countdown all hold. The prior state is saved. When MemBusy drops, resume the saved state, evaluating that cycle's inputs normally.
- Watchdog: when the consecutive load-use stall count reaches MAX_STALL, stall_error<=1. It clears only on reset.
- Counters saturate at all-ones; they never wrap.
- Same-cycle BranchTaken and stall: the flush wins. No bubble is counted in stall_count; the flush is counted in flush_count.
- Reset asserted mid-stall or mid-flush: immediate return to the reset values, with no partial update.

Decomposition:
- Shared pipeline package holds:
  - state enum {RUN, LOAD_STALL, FLUSH, MEM_WAIT};
  - NOP_INSTR constant;
  - XLEN default.
- One sub-module, sat_counter (parameterised width, enable, synchronous hold), is instantiated for stall_count, flush_count and the watchdog run counter.

Test Plan:
- Reset, then feed 3 fetches (PC 0x0, 0x4, 0x8) → IF_IDPc follows one cycle later, IF_IDValid=1, PCWrite=1 throughout, both counters 0.
- stall=1 for 1 cycle with PC 0x10 in IF/ID → PCWrite=0 and ID_EXBubble=1 that cycle, IF_IDPc stays 0x10, stall_count=1, then normal flow.
- BranchTaken=1 with FLUSH_CYCLES=2 → two cycles of IF_IDInstr=0x00000013, IF_IDValid=0, ID_EXBubble=1, flush_count=2, then RUN.
- BranchTaken and stall both high in the same cycle → flush only, stall_count unchanged, flush_count+1.
- MemBusy high for 4 cycles in the middle of a FLUSH_CYCLES=3 flush → PipeFreeze=1, PCWrite=0, IF/ID and counters frozen; after release the remaining flush slots complete, for flush_count=3 total.
- stall held for 8 cycles (MAX_STALL=8) → stall_error=1 after the 8th cycle and stays 1 after stall drops; stall_count saturates at 0xFFFF under a long forced run; rst_n pulse clears everything.
